// File: rtl/serial_uart_bridge_pkg.sv
// Shared types and helpers for the serial UART bridge.
// Line FSM states, data width and a counter-width helper.
package serial_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int DATA_BITS = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_uart_bridge_if.sv
// Processor-facing serial port bundle.
// master = processor side, slave = bridge side.
interface serial_uart_bridge_if;

  logic [7:0] cpu_wdata_in;
  logic       cpu_wren_in;
  logic       cpu_rden_in;
  logic [7:0] cpu_rdata_out;
  logic       cpu_valid_out;
  logic       cpu_ready_out;

  modport master (
    output cpu_wdata_in,
    output cpu_wren_in,
    output cpu_rden_in,
    input  cpu_rdata_out,
    input  cpu_valid_out,
    input  cpu_ready_out
  );

  modport slave (
    input  cpu_wdata_in,
    input  cpu_wren_in,
    input  cpu_rden_in,
    output cpu_rdata_out,
    output cpu_valid_out,
    output cpu_ready_out
  );

endinterface

// File: rtl/serial_uart_bridge_fifo.sv
// Show-ahead byte FIFO, power-of-2 depth.
// Push while full is accepted only when a pop frees a slot on the same edge.
module byte_fifo
  import serial_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/serial_uart_bridge.sv
// 8N1 UART bridge behind the processor serial port.
// TX and RX are independent, each buffered by a byte_fifo.
module serial_uart_bridge
  import serial_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_uart_bridge_if.slave  cpu,
  input  logic                 uart_rx_in,
  output logic                 uart_tx_out,
  output logic                 rx_overrun_out,
  output logic                 rx_frame_err_out
);

  localparam int CW = clog2(CLKS_PER_BIT);
  localparam int BW = clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  // ---------------- TX ----------------
  uart_state_t          tx_state, tx_state_nx;
  logic [CW-1:0]        tx_cnt, tx_cnt_nx;
  logic [BW-1:0]        tx_bit, tx_bit_nx;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nx;
  logic                 tx_pop;
  logic                 tx_full;
  logic                 tx_empty;
  logic [7:0]           tx_head;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cpu.cpu_wren_in && !tx_full),
    .pop   (tx_pop),
    .din   (cpu.cpu_wdata_in),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign cpu.cpu_ready_out = !tx_full;

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    tx_pop      = 1'b0;
    unique case (tx_state)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop      = 1'b1;
          tx_shift_nx = tx_head;
          tx_cnt_nx   = '0;
          tx_state_nx = START;
        end
      end
      START: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_state_nx = DATA;
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      DATA: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_nx   = '0;
          tx_shift_nx = tx_shift >> 1;
          if (tx_bit == BIT_LAST)
            tx_state_nx = STOP;
          else
            tx_bit_nx = tx_bit + 1'b1;
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      STOP: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_nx = '0;
          // Chain straight into the next frame when data is waiting.
          if (!tx_empty) begin
            tx_pop      = 1'b1;
            tx_shift_nx = tx_head;
            tx_state_nx = START;
          end else begin
            tx_state_nx = IDLE;
          end
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      default: tx_state_nx = IDLE;
    endcase
  end

  always_comb begin
    uart_tx_out = 1'b1;
    unique case (tx_state)
      START:   uart_tx_out = 1'b0;
      DATA:    uart_tx_out = tx_shift[0];
      default: uart_tx_out = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  logic [1:0]           rx_sync;
  logic                 rx_s;
  uart_state_t          rx_state, rx_state_nx;
  logic [CW-1:0]        rx_cnt, rx_cnt_nx;
  logic [BW-1:0]        rx_bit, rx_bit_nx;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nx;
  logic                 rx_push;
  logic                 rx_pop;
  logic                 rx_full;
  logic                 rx_empty;
  logic                 rx_ovr_set;
  logic                 rx_err_set;

  assign rx_s   = rx_sync[1];
  assign rx_pop = cpu.cpu_rden_in && !rx_empty;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_shift),
    .dout  (cpu.cpu_rdata_out),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign cpu.cpu_valid_out = !rx_empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_sync          <= 2'b11;
      rx_state         <= IDLE;
      rx_cnt           <= '0;
      rx_bit           <= '0;
      rx_shift         <= '0;
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= 1'b0;
    end else begin
      rx_sync          <= {rx_sync[0], uart_rx_in};
      rx_state         <= rx_state_nx;
      rx_cnt           <= rx_cnt_nx;
      rx_bit           <= rx_bit_nx;
      rx_shift         <= rx_shift_nx;
      rx_overrun_out   <= rx_overrun_out | rx_ovr_set;
      rx_frame_err_out <= rx_err_set;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_push     = 1'b0;
    rx_ovr_set  = 1'b0;
    rx_err_set  = 1'b0;
    unique case (rx_state)
      IDLE: begin
        if (!rx_s) begin
          rx_cnt_nx   = '0;
          rx_state_nx = START;
        end
      end
      START: begin
        // Mid-start re-check rejects short line glitches.
        if (rx_cnt == HALF_END) begin
          rx_cnt_nx   = '0;
          rx_bit_nx   = '0;
          rx_state_nx = rx_s ? IDLE : DATA;
        end else begin
          rx_cnt_nx = rx_cnt + 1'b1;
        end
      end
      DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_s, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == BIT_LAST)
            rx_state_nx = STOP;
          else
            rx_bit_nx = rx_bit + 1'b1;
        end else begin
          rx_cnt_nx = rx_cnt + 1'b1;
        end
      end
      STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_nx   = '0;
          rx_state_nx = IDLE;
          if (!rx_s)
            rx_err_set = 1'b1;
          else if (rx_full && !rx_pop)
            rx_ovr_set = 1'b1;
          else
            rx_push = 1'b1;
        end else begin
          rx_cnt_nx = rx_cnt + 1'b1;
        end
      end
      default: rx_state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Directed bench for serial_uart_bridge (CLKS_PER_BIT=16, depths 4).
// Drives on negedge, samples on negedge after each active edge.
module tb_serial_uart_bridge;

  localparam int CPB = 16;

  logic clock;
  logic reset;
  logic rx_line;
  logic tx_line;
  logic ovr;
  logic ferr;

  int checks = 0;
  int errors = 0;

  serial_uart_bridge_if bus ();

  serial_uart_bridge #(
    .CLKS_PER_BIT (CPB),
    .TX_DEPTH     (4),
    .RX_DEPTH     (4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu              (bus),
    .uart_rx_in       (rx_line),
    .uart_tx_out      (tx_line),
    .rx_overrun_out   (ovr),
    .rx_frame_err_out (ferr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts cycles matching each bit of the expected frame.
  task automatic expect_frame(input logic [7:0] b,
                              input int pre,
                              input string tag);
    logic [9:0] bits;
    int hits;
    int len;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      hits = 0;
      len  = (k == 0) ? CPB - pre : CPB;
      for (int c = 0; c < len; c++) begin
        @(negedge clock);
        if (tx_line === bits[k]) hits++;
      end
      check($sformatf("%s_bit%0d", tag, k), hits, len);
    end
  endtask

  task automatic expect_idle(input int n, input string tag);
    int hits;
    hits = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      if (tx_line === 1'b1) hits++;
    end
    check(tag, hits, n);
  endtask

  task automatic rx_send(input logic [7:0] b,
                         input logic stop,
                         output int ferr_n,
                         output int vrise);
    logic [9:0] bits;
    int idx;
    bits   = {stop, b, 1'b0};
    ferr_n = 0;
    vrise  = 0;
    idx    = 0;
    for (int k = 0; k < 10; k++) begin
      rx_line = bits[k];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clock);
        idx++;
        if (ferr === 1'b1) ferr_n++;
        if (vrise == 0 && bus.cpu_valid_out === 1'b1)
          vrise = idx;
      end
    end
    rx_line = 1'b1;
  endtask

  task automatic cpu_pop();
    bus.cpu_rden_in = 1'b1;
    @(negedge clock);
    bus.cpu_rden_in = 1'b0;
  endtask

  initial begin
    int fe;
    int vr;
    int hits;
    logic [7:0] exp_b;

    reset            = 1'b0;
    rx_line          = 1'b1;
    bus.cpu_wdata_in = 8'h00;
    bus.cpu_wren_in  = 1'b0;
    bus.cpu_rden_in  = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_tx", tx_line, 1);
    check("rst_valid", bus.cpu_valid_out, 0);
    check("rst_ready", bus.cpu_ready_out, 1);
    check("rst_rdata", bus.cpu_rdata_out, 8'h00);
    check("rst_ovr", ovr, 0);
    check("rst_ferr", ferr, 0);
    reset = 1'b1;
    @(negedge clock);

    // TX single byte 0xA5
    bus.cpu_wdata_in = 8'hA5;
    bus.cpu_wren_in  = 1'b1;
    @(negedge clock);
    bus.cpu_wren_in  = 1'b0;
    check("tx1_pre", tx_line, 1);
    expect_frame(8'hA5, 0, "tx1");
    expect_idle(24, "tx1_idle");

    // TX fill: 6 writes on consecutive edges, 6th dropped
    for (int i = 1; i <= 6; i++) begin
      bus.cpu_wdata_in = 8'(i);
      bus.cpu_wren_in  = 1'b1;
      @(negedge clock);
      if (i == 4) check("txf_ready4", bus.cpu_ready_out, 1);
      if (i == 5) check("txf_ready5", bus.cpu_ready_out, 0);
    end
    bus.cpu_wren_in = 1'b0;
    check("txf_ready6", bus.cpu_ready_out, 0);
    expect_frame(8'h01, 5, "txf1");
    expect_frame(8'h02, 0, "txf2");
    expect_frame(8'h03, 0, "txf3");
    expect_frame(8'h04, 0, "txf4");
    expect_frame(8'h05, 0, "txf5");
    expect_idle(40, "txf_idle");
    check("txf_ready_end", bus.cpu_ready_out, 1);

    // RX single 0x3C
    rx_send(8'h3C, 1'b1, fe, vr);
    check("rx1_ferr", fe, 0);
    check("rx1_vrise", vr, 155);
    check("rx1_valid", bus.cpu_valid_out, 1);
    check("rx1_data", bus.cpu_rdata_out, 8'h3C);
    cpu_pop();
    check("rx1_popped", bus.cpu_valid_out, 0);
    cpu_pop();
    check("rx1_empty_pop", bus.cpu_valid_out, 0);
    check("rx1_empty_rdata", bus.cpu_rdata_out, 8'h00);

    // RX frame error
    rx_send(8'h77, 1'b0, fe, vr);
    check("rxe_ferr_cycles", fe, 1);
    check("rxe_no_push", vr, 0);
    repeat (4) @(negedge clock);
    check("rxe_valid", bus.cpu_valid_out, 0);

    // RX 4-cycle glitch, then a clean frame
    rx_line = 1'b0;
    repeat (4) @(negedge clock);
    rx_line = 1'b1;
    hits = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (ferr === 1'b1 || bus.cpu_valid_out === 1'b1) hits++;
    end
    check("rxg_quiet", hits, 0);
    rx_send(8'h5A, 1'b1, fe, vr);
    check("rxg_next_vrise", vr, 155);
    check("rxg_next_data", bus.cpu_rdata_out, 8'h5A);
    cpu_pop();
    check("rxg_next_empty", bus.cpu_valid_out, 0);

    // RX overrun and ordering
    for (int i = 0; i < 5; i++) begin
      exp_b = 8'h10 + 8'(i);
      rx_send(exp_b, 1'b1, fe, vr);
      if (i == 3) check("rxo_ovr_before", ovr, 0);
    end
    check("rxo_ovr", ovr, 1);
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h10 + 8'(i);
      check($sformatf("rxo_valid%0d", i), bus.cpu_valid_out, 1);
      check($sformatf("rxo_data%0d", i), bus.cpu_rdata_out, exp_b);
      cpu_pop();
    end
    check("rxo_empty", bus.cpu_valid_out, 0);
    check("rxo_ovr_sticky", ovr, 1);

    // Reset mid TX frame
    bus.cpu_wdata_in = 8'h00;
    bus.cpu_wren_in  = 1'b1;
    @(negedge clock);
    bus.cpu_wren_in  = 1'b0;
    repeat (40) @(negedge clock);
    check("rstm_tx_low", tx_line, 0);
    reset = 1'b0;
    @(negedge clock);
    check("rstm_tx", tx_line, 1);
    check("rstm_ovr", ovr, 0);
    check("rstm_ready", bus.cpu_ready_out, 1);
    reset = 1'b1;
    expect_idle(200, "rstm_idle");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_uart_bridge.md
Name: serial_uart_bridge

Overview:
- Peripheral on the far side of the processor's serial IO ports.
- Accepts bytes the processor writes (serial_out / serial_wren_out) and transmits them as 8N1 UART frames.
- Receives 8N1 frames from a UART line and presents them to the processor (serial_in / serial_valid_in), popping one on serial_rden_out.
- Buffers each direction in a small FIFO so processor loads and stores never wait on line timing.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; even, >= 4.
- TX_DEPTH, 4, TX FIFO entries; power of 2, >= 2.
- RX_DEPTH, 4, RX FIFO entries; power of 2, >= 2.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clock).
- cpu_wdata_in  in  8  byte from processor serial_out.
- cpu_wren_in  in  1  from serial_wren_out; push cpu_wdata_in into TX FIFO.
- cpu_rden_in  in  1  from serial_rden_out; pop RX FIFO head.
- cpu_rdata_out  out  8  to serial_in; RX FIFO head (show-ahead).
- cpu_valid_out  out  1  to serial_valid_in; RX FIFO non-empty.
- cpu_ready_out  out  1  to serial_ready_in; TX FIFO not full.
- uart_rx_in  in  1  asynchronous serial line in, idle high.
- uart_tx_out  out  1  serial line out, idle high.
- rx_overrun_out  out  1  sticky: a received byte was dropped because RX FIFO was full.
- rx_frame_err_out  out  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset values: uart_tx_out=1, cpu_valid_out=0, cpu_ready_out=1, cpu_rdata_out=0x00, rx_overrun_out=0, rx_frame_err_out=0.
- Reset also empties both FIFOs, forces both FSMs to IDLE, and sets synchronizer flops to 1. Reset mid-frame aborts the frame; uart_tx_out=1 from the next edge.
- CPU write side:
  - cpu_wren_in=1 with cpu_ready_out=1 pushes on that edge.
  - A write while full is dropped with no other effect.
  - cpu_ready_out is combinational from FIFO count.
- CPU read side:
  - cpu_rdata_out is valid whenever cpu_valid_out=1.
  - cpu_rden_in=1 with valid pops on that edge; cpu_rden_in=1 while empty is ignored.
  - Simultaneous push and pop on the same FIFO is legal; count is unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when TX FIFO is non-empty. Byte is popped into a shift register on that edge, so a byte written at edge N drives uart_tx_out=0 from edge N+1 if idle.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - DATA shifts 8 bits, LSB first.
  - At end of STOP (high): -> START if FIFO is non-empty (back-to-back, no idle gap), else IDLE.
  - Frame length is 10*CLKS_PER_BIT cycles.
- RX path:
  - uart_rx_in passes through a 2-flop synchronizer before the FSM.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronized 0.
  - At CLKS_PER_BIT/2 into START, re-sample: if 1, treat as glitch and return to IDLE; if 0, continue.
  - DATA samples 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint, LSB first.
  - STOP samples once, then returns to IDLE.
- Stop-bit outcomes:
  - Stop=1, FIFO not full: push the byte; cpu_valid_out rises the cycle after the stop-bit sample edge.
  - Stop=1, FIFO full (after any same-edge pop): drop the byte and set rx_overrun_out (cleared only by reset).
  - Stop=0: discard the byte and pulse rx_frame_err_out for one cycle.
- TX and RX are fully independent; no ordering between them.

Decomposition:
- Shared package serial_uart_pkg:
  - uart_state_t enum {IDLE, START, DATA, STOP}
  - DATA_BITS=8
  - bit-counter width function clog2
- One sub-module, byte_fifo (params DEPTH; ports clock, reset, push, pop, din, dout, full, empty), instantiated twice: TX and RX.
- TX and RX FSMs live in the top block.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> uart_tx_out=1, cpu_valid_out=0, cpu_ready_out=1, rx_overrun_out=0.
- TX single (CLKS_PER_BIT=16): write 0xA5 -> uart_tx_out is low for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16 cycles; total 160 cycles, then idle high.
- TX full: write 0x01..0x06 on 6 consecutive edges -> cpu_ready_out=0 after the 5th write and the 6th is dropped; five back-to-back frames 0x01..0x05 are emitted with no idle gap.
- RX single: drive 8N1 frame 0x3C -> cpu_valid_out=1 with cpu_rdata_out=0x3C; pulse cpu_rden_in -> cpu_valid_out=0 next cycle.
- RX overrun/order: drive 0x10..0x14 with no reads -> rx_overrun_out=1; four reads return 0x10,0x11,0x12,0x13, then cpu_valid_out=0.
- RX errors: frame with stop bit 0 -> rx_frame_err_out pulses one cycle and no push; 4-cycle low glitch -> no push, no error, FSM back in IDLE.
